// File: rtl/tsc_pkg.sv
// Shared constants and FSM encoding for the transient-capture ADC sequencer.
package tsc_pkg;

   // Default widths and timing used by the sequencer and the capture core
   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned TS_W_DEF       = 32;
   localparam int unsigned PER_W_DEF      = 16;
   localparam int unsigned PERIOD_MIN_DEF = 4;
   localparam int unsigned TIMEOUT_DEF    = 1024;
   localparam int unsigned RST_CYCLES_DEF = 4;

   // ADC handshake constants
   localparam logic ADC_RST_ASSERT   = 1'b1;
   localparam logic ADC_RST_DEASSERT = 1'b0;

   // Overrun counter width and saturation value
   localparam int unsigned      OVR_W   = 8;
   localparam logic [OVR_W-1:0] OVR_MAX = '1;

   // FSM state encoding
   localparam logic [2:0] ST_ADC_RST   = 3'd0;
   localparam logic [2:0] ST_IDLE      = 3'd1;
   localparam logic [2:0] ST_WAIT_TICK = 3'd2;
   localparam logic [2:0] ST_REQ       = 3'd3;
   localparam logic [2:0] ST_RELEASE   = 3'd4;
   localparam logic [2:0] ST_ERR       = 3'd5;

   typedef enum logic [2:0] {
      StAdcRst   = ST_ADC_RST,
      StIdle     = ST_IDLE,
      StWaitTick = ST_WAIT_TICK,
      StReq      = ST_REQ,
      StRelease  = ST_RELEASE,
      StErr      = ST_ERR
   } state_e;

endpackage

// File: rtl/tsc_tick_gen.sv
// Free-running sample tick divider: one-cycle tick every 'per' cycles while enabled.
module tsc_tick_gen #(
   parameter int unsigned PER_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [PER_W-1:0] per,
   output logic             tick
);

   localparam logic [PER_W-1:0] ONE = PER_W'(1);

   logic [PER_W-1:0] cnt_q;

   // Tick fires in the last cycle of each period
   assign tick = en && (cnt_q == (per - ONE));

   // Divider counter; clear restarts phase so the first tick lands 'per' cycles later
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + ONE;
      end
   end

endmodule

// File: rtl/tsc_adc_sequencer.sv
// ADC conversion sequencer: paces conversions, runs the 4-phase req/rdy handshake,
// delivers timestamped sample strobes and handles timeout recovery and overruns.
module tsc_adc_sequencer
   import tsc_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned TS_W       = TS_W_DEF,
   parameter int unsigned PER_W      = PER_W_DEF,
   parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
   parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [PER_W-1:0]  period,
   output logic              adc_req,
   input  logic              adc_rdy,
   input  logic [DATA_W-1:0] adc_dat,
   output logic              adc_rst,
   output logic              smp_valid,
   output logic [DATA_W-1:0] smp_data,
   output logic [TS_W-1:0]   smp_time,
   output logic              busy,
   output logic              err_to,
   output logic [OVR_W-1:0]  ovr_cnt
);

   localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
   localparam logic [PER_W-1:0] PMIN    = PER_W'(PERIOD_MIN);

   state_e            state_q;
   logic [PER_W-1:0]  per_q;
   logic [TS_W-1:0]   tick_idx_q;
   logic [TS_W-1:0]   req_idx_q;
   logic              stop_pend_q;
   logic [TO_W-1:0]   wait_cnt_q;
   logic [RC_W-1:0]   rst_cnt_q;
   logic              tick;
   logic              start_ok;
   logic [PER_W-1:0]  per_clamped;

   assign start_ok    = (state_q == StIdle) && start && !stop;
   assign per_clamped = (period < PMIN) ? PMIN : period;

   tsc_tick_gen #(
      .PER_W (PER_W)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clear (start_ok),
      .en    (busy),
      .per   (per_q),
      .tick  (tick)
   );

   // Sequencer FSM with registered outputs, tick index, overrun and timeout accounting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StAdcRst;
         adc_rst     <= ADC_RST_ASSERT;
         adc_req     <= 1'b0;
         busy        <= 1'b0;
         err_to      <= 1'b0;
         ovr_cnt     <= '0;
         smp_valid   <= 1'b0;
         smp_data    <= '0;
         smp_time    <= '0;
         per_q       <= PMIN;
         tick_idx_q  <= '0;
         req_idx_q   <= '0;
         stop_pend_q <= 1'b0;
         wait_cnt_q  <= '0;
         rst_cnt_q   <= '0;
      end else begin
         smp_valid  <= 1'b0;
         // Only REQ/RELEASE advance this; any other state or transition leaves it cleared
         wait_cnt_q <= '0;

         // Every tick advances the index, skipped or not
         if (tick) begin
            tick_idx_q <= tick_idx_q + 1'b1;
         end
         if (tick && (state_q == StReq || state_q == StRelease) && ovr_cnt != OVR_MAX) begin
            ovr_cnt <= ovr_cnt + 1'b1;
         end

         unique case (state_q)
            StAdcRst, StErr: begin
               if (rst_cnt_q == RC_LAST) begin
                  adc_rst   <= ADC_RST_DEASSERT;
                  rst_cnt_q <= '0;
                  state_q   <= StIdle;
               end else begin
                  rst_cnt_q <= rst_cnt_q + 1'b1;
               end
            end
            StIdle: begin
               if (start_ok) begin
                  per_q       <= per_clamped;
                  tick_idx_q  <= '0;
                  ovr_cnt     <= '0;
                  err_to      <= 1'b0;
                  busy        <= 1'b1;
                  stop_pend_q <= 1'b0;
                  state_q     <= StWaitTick;
               end
            end
            StWaitTick: begin
               if (stop) begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end else if (tick) begin
                  adc_req   <= 1'b1;
                  req_idx_q <= tick_idx_q;
                  state_q   <= StReq;
               end
            end
            StReq: begin
               if (stop) begin
                  stop_pend_q <= 1'b1;
               end
               if (adc_rdy) begin
                  smp_data  <= adc_dat;
                  smp_time  <= req_idx_q;
                  smp_valid <= 1'b1;
                  adc_req   <= 1'b0;
                  state_q   <= StRelease;
               end else if (wait_cnt_q == TO_LAST) begin
                  err_to      <= 1'b1;
                  busy        <= 1'b0;
                  adc_req     <= 1'b0;
                  adc_rst     <= ADC_RST_ASSERT;
                  rst_cnt_q   <= '0;
                  stop_pend_q <= 1'b0;
                  state_q     <= StErr;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StRelease: begin
               if (stop) begin
                  stop_pend_q <= 1'b1;
               end
               // 4-phase: no new request until the ADC drops rdy
               if (!adc_rdy) begin
                  if (stop_pend_q || stop) begin
                     busy    <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StWaitTick;
                  end
               end else if (wait_cnt_q == TO_LAST) begin
                  err_to      <= 1'b1;
                  busy        <= 1'b0;
                  adc_rst     <= ADC_RST_ASSERT;
                  rst_cnt_q   <= '0;
                  stop_pend_q <= 1'b0;
                  state_q     <= StErr;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            default: begin
               adc_rst   <= ADC_RST_ASSERT;
               rst_cnt_q <= '0;
               state_q   <= StAdcRst;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tsc_adc_sequencer.sv
// Directed self-checking bench for tsc_adc_sequencer with a simple 4-phase ADC model.
module tb_tsc_adc_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic [15:0] period;
   logic        adc_req;
   logic        adc_rdy;
   logic [7:0]  adc_dat;
   logic        adc_rst;
   logic        smp_valid;
   logic [7:0]  smp_data;
   logic [31:0] smp_time;
   logic        busy;
   logic        err_to;
   logic [7:0]  ovr_cnt;

   int errors = 0;
   int checks = 0;

   // ADC model controls
   int       m_dly   = 3;
   bit       m_never = 1'b0;
   logic [7:0] m_dat = 8'h00;
   int       m_cnt   = 0;

   // Captured sample strobes
   int          nv;
   int          v_n[16];
   logic [31:0] v_time[16];
   logic [7:0]  v_data[16];
   logic [7:0]  v_ovr[16];

   tsc_adc_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .period    (period),
      .adc_req   (adc_req),
      .adc_rdy   (adc_rdy),
      .adc_dat   (adc_dat),
      .adc_rst   (adc_rst),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .smp_time  (smp_time),
      .busy      (busy),
      .err_to    (err_to),
      .ovr_cnt   (ovr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC: raises rdy m_dly cycles after seeing req, drops it once req falls
   initial begin
      adc_rdy = 1'b0;
      adc_dat = 8'h00;
      forever begin
         @(negedge clk);
         if (!adc_req) begin
            adc_rdy = 1'b0;
            m_cnt   = 0;
         end else if (!adc_rdy && !m_never) begin
            m_cnt++;
            if (m_cnt >= m_dly) begin
               adc_rdy = 1'b1;
               adc_dat = m_dat;
            end
         end
      end
   end

   // Start pulse; returns on the negedge right after the accepting posedge (n = 0)
   task automatic do_start(input logic [15:0] p);
      @(negedge clk);
      period = p;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   // Records every strobe seen on negedges 1..nmax after do_start
   task automatic collect(input int nmax);
      nv = 0;
      for (int n = 1; n <= nmax; n++) begin
         @(negedge clk);
         if (smp_valid && nv < 16) begin
            v_n[nv]    = n;
            v_time[nv] = smp_time;
            v_data[nv] = smp_data;
            v_ovr[nv]  = ovr_cnt;
            nv++;
         end
      end
   endtask

   task automatic test_reset();
      int rst_hi;
      int req_hi;
      start  = 1'b0;
      stop   = 1'b0;
      period = 16'd0;
      reset  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (adc_rst !== 1'b1 || busy !== 1'b0 || err_to !== 1'b0 || ovr_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: adc_rst=%b busy=%b err_to=%b ovr=%0d want 1 0 0 0",
                  adc_rst, busy, err_to, ovr_cnt);
      end
      checks++;
      if (adc_req !== 1'b0 || smp_valid !== 1'b0 || smp_data !== 8'd0 || smp_time !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b valid=%b data=%0h time=%0d want all 0",
                  adc_req, smp_valid, smp_data, smp_time);
      end
      reset  = 1'b1;
      #1;
      rst_hi = 0;
      req_hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (adc_rst) rst_hi++;
         if (adc_req) req_hi++;
         @(negedge clk);
      end
      checks++;
      if (rst_hi != 4) begin
         errors++;
         $display("FAIL adc_rst_len: got %0d cycles want 4", rst_hi);
      end
      checks++;
      if (adc_rst !== 1'b0 || busy !== 1'b0 || req_hi != 0) begin
         errors++;
         $display("FAIL post_reset_idle: adc_rst=%b busy=%b req_cycles=%0d want 0 0 0",
                  adc_rst, busy, req_hi);
      end
   endtask

   task automatic test_steady();
      m_dly   = 3;
      m_never = 1'b0;
      m_dat   = 8'h5A;
      do_start(16'd10);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL steady_busy: got %b want 1", busy);
      end
      collect(45);
      checks++;
      if (nv != 4) begin
         errors++;
         $display("FAIL steady_count: got %0d samples want 4", nv);
      end
      for (int i = 0; i < nv && i < 4; i++) begin
         checks++;
         if (v_n[i] != 13 + 10 * i || v_time[i] !== 32'(i) || v_data[i] !== 8'h5A
             || v_ovr[i] !== 8'd0) begin
            errors++;
            $display("FAIL steady_sample%0d: cyc=%0d time=%0d data=%0h ovr=%0d want %0d %0d 5a 0",
                     i, v_n[i], v_time[i], v_data[i], v_ovr[i], 13 + 10 * i, i);
         end
      end
      do_stop();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_wait_tick: busy=%b want 0", busy);
      end
   endtask

   task automatic test_overrun();
      m_dly = 15;
      m_dat = 8'hC3;
      do_start(16'd10);
      collect(66);
      checks++;
      if (nv != 3) begin
         errors++;
         $display("FAIL ovr_count: got %0d samples want 3", nv);
      end
      for (int i = 0; i < nv && i < 3; i++) begin
         checks++;
         if (v_n[i] != 25 + 20 * i || v_time[i] !== 32'(2 * i) || v_data[i] !== 8'hC3
             || v_ovr[i] !== 8'(i + 1)) begin
            errors++;
            $display("FAIL ovr_sample%0d: cyc=%0d time=%0d data=%0h ovr=%0d want %0d %0d c3 %0d",
                     i, v_n[i], v_time[i], v_data[i], v_ovr[i], 25 + 20 * i, 2 * i, i + 1);
         end
      end
      do_stop();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ovr_stop: busy=%b want 0", busy);
      end
   endtask

   task automatic test_timeout();
      int rst_hi;
      m_never = 1'b1;
      do_start(16'd2);
      rst_hi = 0;
      for (int n = 1; n <= 1035; n++) begin
         @(negedge clk);
         if (n >= 1028 && adc_rst) rst_hi++;
         if (n == 3) begin
            checks++;
            if (adc_req !== 1'b0) begin
               errors++;
               $display("FAIL clamp_early: adc_req=%b at cycle 3 want 0", adc_req);
            end
         end
         if (n == 4) begin
            checks++;
            if (adc_req !== 1'b1) begin
               errors++;
               $display("FAIL clamp_tick: adc_req=%b at cycle 4 want 1", adc_req);
            end
         end
         if (n == 1027) begin
            checks++;
            if (err_to !== 1'b0 || adc_req !== 1'b1 || ovr_cnt !== 8'd255) begin
               errors++;
               $display("FAIL to_before: err_to=%b req=%b ovr=%0d want 0 1 255",
                        err_to, adc_req, ovr_cnt);
            end
         end
         if (n == 1028) begin
            checks++;
            if (err_to !== 1'b1 || busy !== 1'b0 || adc_req !== 1'b0 || ovr_cnt !== 8'd255) begin
               errors++;
               $display("FAIL to_enter: err_to=%b busy=%b req=%b ovr=%0d want 1 0 0 255",
                        err_to, busy, adc_req, ovr_cnt);
            end
         end
         if (n == 1029) start = 1'b1;
         if (n == 1030) start = 1'b0;
         if (n == 1031) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL start_in_err: busy=%b want 0", busy);
            end
         end
      end
      checks++;
      if (rst_hi != 4 || adc_rst !== 1'b0 || err_to !== 1'b1) begin
         errors++;
         $display("FAIL to_adc_rst: cycles=%0d adc_rst=%b err_to=%b want 4 0 1",
                  rst_hi, adc_rst, err_to);
      end
      m_never = 1'b0;
      m_dly   = 3;
      do_start(16'd10);
      checks++;
      if (err_to !== 1'b0 || busy !== 1'b1 || ovr_cnt !== 8'd0) begin
         errors++;
         $display("FAIL restart_clears: err_to=%b busy=%b ovr=%0d want 0 1 0",
                  err_to, busy, ovr_cnt);
      end
      do_stop();
   endtask

   task automatic test_stop_in_req();
      int late_req;
      int samples;
      m_dly   = 3;
      m_dat   = 8'h3C;
      late_req = 0;
      samples  = 0;
      do_start(16'd10);
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (smp_valid) samples++;
         if (n >= 15 && adc_req) late_req++;
         if (n == 10) begin
            checks++;
            if (adc_req !== 1'b1) begin
               errors++;
               $display("FAIL stop_req_state: adc_req=%b want 1", adc_req);
            end
         end
         if (n == 11) stop = 1'b1;
         if (n == 12) stop = 1'b0;
         if (n == 13) begin
            checks++;
            if (smp_valid !== 1'b1 || smp_data !== 8'h3C || smp_time !== 32'd0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL stop_sample: valid=%b data=%0h time=%0d busy=%b want 1 3c 0 1",
                        smp_valid, smp_data, smp_time, busy);
            end
         end
         if (n == 14) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL stop_idle: busy=%b want 0", busy);
            end
         end
      end
      checks++;
      if (samples != 1 || late_req != 0) begin
         errors++;
         $display("FAIL stop_after: samples=%0d late_req=%0d want 1 0", samples, late_req);
      end
   endtask

   task automatic test_start_stop_conflict();
      int req_hi;
      req_hi = 0;
      @(negedge clk);
      period = 16'd10;
      start  = 1'b1;
      stop   = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      stop   = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_stop_busy: busy=%b want 0", busy);
      end
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (adc_req) req_hi++;
      end
      checks++;
      if (req_hi != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_stop_quiet: req_cycles=%0d busy=%b want 0 0", req_hi, busy);
      end
   endtask

   task automatic test_reset_mid();
      m_dly = 15;
      do_start(16'd10);
      repeat (22) @(negedge clk);
      checks++;
      if (adc_req !== 1'b1 || ovr_cnt !== 8'd1) begin
         errors++;
         $display("FAIL mid_pre: adc_req=%b ovr=%0d want 1 1", adc_req, ovr_cnt);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (adc_req !== 1'b0 || adc_rst !== 1'b1 || ovr_cnt !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: req=%b adc_rst=%b ovr=%0d busy=%b want 0 1 0 0",
                  adc_req, adc_rst, ovr_cnt, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (adc_rst !== 1'b0 || adc_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_recover: adc_rst=%b req=%b busy=%b want 0 0 0",
                  adc_rst, adc_req, busy);
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_overrun();
      test_timeout();
      test_stop_in_req();
      test_start_stop_conflict();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
